// File: rtl/tlu_emulator.sv
// Trigger Logic Unit emulator: LFSR-rate trigger source with no-handshake,
// simple-handshake and serial-ID data-handshake modes for tlu_controller loopback.
module tlu_emulator #(
  parameter int                    TRIG_ID_WIDTH  = 15,
  parameter int                    RATE_WIDTH     = 16,
  parameter logic [RATE_WIDTH-1:0] LFSR_SEED      = 16'hACE1,
  parameter int                    TRIG_PULSE_LEN = 4,
  parameter int                    HOLDOFF        = 2,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                     SYS_CLK,
  input  logic                     SYS_RST,
  input  logic                     ENABLE,
  input  logic [1:0]               MODE,
  input  logic [RATE_WIDTH-1:0]    RATE_THRESHOLD,
  input  logic                     RESET_REQ,
  input  logic                     TLU_CLOCK,
  input  logic                     TLU_BUSY,
  output logic                     TLU_TRIGGER,
  output logic                     TLU_RESET,
  output logic [TRIG_ID_WIDTH-1:0] TRIG_ID,
  output logic [31:0]              TRIG_COUNT,
  output logic                     TIMEOUT_ERR,
  output logic                     ACTIVE
);

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_WAIT_BUSY_HI, S_SHIFT, S_WAIT_BUSY_LO, S_HOLD
  } state_t;

  // Right-shifting Galois feedback masks for maximal-length sequences.
  localparam logic [31:0] TAPS32 =
      (RATE_WIDTH == 4)  ? 32'h0000_000C :
      (RATE_WIDTH == 5)  ? 32'h0000_0014 :
      (RATE_WIDTH == 6)  ? 32'h0000_0030 :
      (RATE_WIDTH == 7)  ? 32'h0000_0060 :
      (RATE_WIDTH == 8)  ? 32'h0000_00B8 :
      (RATE_WIDTH == 10) ? 32'h0000_0240 :
      (RATE_WIDTH == 12) ? 32'h0000_0E08 :
      (RATE_WIDTH == 20) ? 32'h0009_0000 :
      (RATE_WIDTH == 24) ? 32'h00E1_0000 :
      (RATE_WIDTH == 32) ? 32'h8020_0003 : 32'h0000_B400;
  localparam logic [RATE_WIDTH-1:0] TAPS = TAPS32[RATE_WIDTH-1:0];

  localparam int CNT_MAX0  = (TIMEOUT_CYCLES > TRIG_PULSE_LEN) ? TIMEOUT_CYCLES : TRIG_PULSE_LEN;
  localparam int CNT_MAX   = (CNT_MAX0 > HOLDOFF) ? CNT_MAX0 : HOLDOFF;
  localparam int CNT_W     = $clog2(CNT_MAX + 1) + 1;
  localparam int BIT_W     = $clog2(TRIG_ID_WIDTH + 2);
  localparam int HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam state_t POST_SEQ = (HOLDOFF == 0) ? S_IDLE : S_HOLD;

  state_t                   state_q;
  logic [RATE_WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [1:0]               mode_q;
  logic [TRIG_ID_WIDTH-1:0] sr_q, trig_id_q;
  logic [BIT_W-1:0]         bit_cnt_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     tlu_clock_q, trig_q, tlu_reset_q, timeout_err_q;
  logic [31:0]              trig_count_q;
  logic                     clk_rise, fire, timed_out;

  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[RATE_WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    clk_rise  = TLU_CLOCK & ~tlu_clock_q;
    timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    fire      = (state_q == S_IDLE) && ENABLE && (lfsr_q < RATE_THRESHOLD) &&
                !((MODE == 2'd2) && TLU_CLOCK);
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      mode_q        <= 2'd0;
      sr_q          <= '0;
      trig_id_q     <= '0;
      bit_cnt_q     <= '0;
      cnt_q         <= '0;
      tlu_clock_q   <= 1'b0;
      trig_q        <= 1'b0;
      tlu_reset_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      trig_count_q  <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      tlu_clock_q <= TLU_CLOCK;
      tlu_reset_q <= 1'b0;
      if (RESET_REQ) begin
        tlu_reset_q   <= 1'b1;
        trig_q        <= 1'b0;
        trig_id_q     <= '0;
        trig_count_q  <= '0;
        timeout_err_q <= 1'b0;
        cnt_q         <= '0;
        state_q       <= POST_SEQ;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fire) begin
              mode_q       <= MODE;
              sr_q         <= trig_id_q;
              trig_id_q    <= trig_id_q + 1'b1;
              trig_count_q <= trig_count_q + 32'd1;
              trig_q       <= 1'b1;
              cnt_q        <= '0;
              bit_cnt_q    <= '0;
              state_q      <= (MODE == 2'd0) ? S_PULSE : S_WAIT_BUSY_HI;
            end
          end
          S_PULSE: begin
            if (cnt_q == CNT_W'(TRIG_PULSE_LEN - 1)) begin
              trig_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= POST_SEQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_WAIT_BUSY_HI: begin
            // A busy seen in the same cycle as the timeout still counts as a response.
            if (TLU_BUSY) begin
              trig_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= (mode_q == 2'd2) ? S_SHIFT : S_WAIT_BUSY_LO;
            end else if (timed_out) begin
              timeout_err_q <= 1'b1;
              trig_q        <= 1'b0;
              cnt_q         <= '0;
              state_q       <= POST_SEQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SHIFT: begin
            if (clk_rise && (bit_cnt_q == BIT_W'(TRIG_ID_WIDTH))) begin
              trig_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_WAIT_BUSY_LO;
            end else if (timed_out) begin
              timeout_err_q <= 1'b1;
              trig_q        <= 1'b0;
              cnt_q         <= '0;
              state_q       <= POST_SEQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (clk_rise) begin
                trig_q    <= sr_q[0];
                sr_q      <= sr_q >> 1;
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          S_WAIT_BUSY_LO: begin
            if (!TLU_BUSY) begin
              cnt_q   <= '0;
              state_q <= POST_SEQ;
            end else if (timed_out) begin
              timeout_err_q <= 1'b1;
              trig_q        <= 1'b0;
              cnt_q         <= '0;
              state_q       <= POST_SEQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_HOLD: begin
            if (cnt_q == CNT_W'(HOLD_LAST)) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign TLU_TRIGGER = trig_q;
  assign TLU_RESET   = tlu_reset_q;
  assign TRIG_ID     = trig_id_q;
  assign TRIG_COUNT  = trig_count_q;
  assign TIMEOUT_ERR = timeout_err_q;
  assign ACTIVE      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tlu_emulator.sv
// Directed self-checking bench for tlu_emulator: modes 0/1/2, timeout,
// reset request, ID wrap, zero rate threshold and mid-sequence system reset.
module tb_tlu_emulator;

  localparam int W = 4;

  logic          SYS_CLK = 1'b0;
  logic          SYS_RST = 1'b1;
  logic          ENABLE = 1'b0;
  logic [1:0]    MODE = 2'd0;
  logic [15:0]   RATE_THRESHOLD = 16'hFFFF;
  logic          RESET_REQ = 1'b0;
  logic          TLU_CLOCK = 1'b0;
  logic          TLU_BUSY = 1'b0;
  logic          TLU_TRIGGER, TLU_RESET, TIMEOUT_ERR, ACTIVE;
  logic [W-1:0]  TRIG_ID;
  logic [31:0]   TRIG_COUNT;

  int checks = 0;
  int errors = 0;

  tlu_emulator #(
    .TRIG_ID_WIDTH(W), .RATE_WIDTH(16), .LFSR_SEED(16'hACE1),
    .TRIG_PULSE_LEN(4), .HOLDOFF(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE), .MODE(MODE),
    .RATE_THRESHOLD(RATE_THRESHOLD), .RESET_REQ(RESET_REQ),
    .TLU_CLOCK(TLU_CLOCK), .TLU_BUSY(TLU_BUSY), .TLU_TRIGGER(TLU_TRIGGER),
    .TLU_RESET(TLU_RESET), .TRIG_ID(TRIG_ID), .TRIG_COUNT(TRIG_COUNT),
    .TIMEOUT_ERR(TIMEOUT_ERR), .ACTIVE(ACTIVE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_high(output int n);
    n = 0;
    while (TLU_TRIGGER !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ACTIVE !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic count_high(output int h);
    h = 0;
    while (TLU_TRIGGER === 1'b1 && h < 300) begin
      h++;
      tick();
    end
  endtask

  initial begin
    int n, h, a, hi, lo_act;
    logic [4:0] bits5;
    logic [3:0] bits4;

    repeat (3) tick();
    SYS_RST = 1'b0;
    check("rst_trig", 32'(TLU_TRIGGER), 0);
    check("rst_tlu_reset", 32'(TLU_RESET), 0);
    check("rst_id", 32'(TRIG_ID), 0);
    check("rst_count", TRIG_COUNT, 0);
    check("rst_err", 32'(TIMEOUT_ERR), 0);
    check("rst_active", 32'(ACTIVE), 0);

    // Mode 0: three pulses of 4 cycles, at least 3 low cycles between them
    MODE = 2'd0;
    ENABLE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_high(n);
      check("m0_rise", 32'(TLU_TRIGGER), 1);
      if (k == 0) check("m0_first_id", 32'(TRIG_ID), 1);
      else check("m0_gap_ge3", 32'(n >= 3), 1);
      if (k == 2) ENABLE = 1'b0;
      count_high(h);
      check("m0_width", h, 4);
    end
    wait_idle();
    check("m0_id", 32'(TRIG_ID), 3);
    check("m0_count", TRIG_COUNT, 3);

    // Mode 1: busy 3 cycles after trigger, held 10 cycles
    MODE = 2'd1;
    ENABLE = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_high(n);
      check("m1_rise", 32'(TLU_TRIGGER), 1);
      hi = 1;
      for (int i = 0; i < 3; i++) begin tick(); hi += int'(TLU_TRIGGER); end
      TLU_BUSY = 1'b1;
      tick();
      hi += int'(TLU_TRIGGER);
      check("m1_high_cycles", hi, 4);
      hi = 0; lo_act = 0;
      for (int i = 0; i < 9; i++) begin
        tick();
        hi += int'(TLU_TRIGGER);
        lo_act += int'(!ACTIVE);
      end
      check("m1_no_trig_busy", hi, 0);
      check("m1_active_busy", lo_act, 0);
      TLU_BUSY = 1'b0;
      tick();
      a = 0;
      while (ACTIVE === 1'b1 && a < 50) begin a++; tick(); end
      check("m1_hold_active", a, 2);
      if (k == 1) ENABLE = 1'b0;
    end
    check("m1_id", 32'(TRIG_ID), 5);

    // Mode 2: no fire while TLU_CLOCK high, then serial readout of ID 5
    MODE = 2'd2;
    TLU_CLOCK = 1'b1;
    ENABLE = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin tick(); hi += int'(TLU_TRIGGER); end
    check("m2_clk_block", hi, 0);
    TLU_CLOCK = 1'b0;
    wait_high(n);
    ENABLE = 1'b0;
    check("m2_rise", 32'(TLU_TRIGGER), 1);
    tick(); tick();
    TLU_BUSY = 1'b1;
    tick();
    check("m2_trig_after_busy", 32'(TLU_TRIGGER), 0);
    bits5 = 5'b00101;
    for (int b = 0; b < 5; b++) begin
      TLU_CLOCK = 1'b1;
      tick();
      check($sformatf("m2_bit%0d", b), 32'(TLU_TRIGGER), 32'(bits5[b]));
      tick();
      TLU_CLOCK = 1'b0;
      tick(); tick();
    end
    check("m2_active_lo_wait", 32'(ACTIVE), 1);
    TLU_BUSY = 1'b0;
    wait_idle();
    check("m2_id", 32'(TRIG_ID), 6);

    // Timeout in mode 1 with busy never raised
    check("to_err_before", 32'(TIMEOUT_ERR), 0);
    MODE = 2'd1;
    ENABLE = 1'b1;
    wait_high(n);
    ENABLE = 1'b0;
    count_high(h);
    check("to_high_cycles", h, 64);
    check("to_err_set", 32'(TIMEOUT_ERR), 1);
    wait_idle();
    MODE = 2'd0;
    ENABLE = 1'b1;
    wait_high(n);
    ENABLE = 1'b0;
    count_high(h);
    check("to_next_width", h, 4);
    check("to_err_sticky", 32'(TIMEOUT_ERR), 1);
    wait_idle();
    check("to_id", 32'(TRIG_ID), 8);

    // Reset request during the serial readout of ID 8, after bit 3
    MODE = 2'd2;
    ENABLE = 1'b1;
    wait_high(n);
    ENABLE = 1'b0;
    tick(); tick();
    TLU_BUSY = 1'b1;
    tick();
    bits4 = 4'b1000;
    for (int b = 0; b < 4; b++) begin
      TLU_CLOCK = 1'b1;
      tick();
      check($sformatf("rr_bit%0d", b), 32'(TLU_TRIGGER), 32'(bits4[b]));
      if (b < 3) begin
        tick();
        TLU_CLOCK = 1'b0;
        tick(); tick();
      end
    end
    RESET_REQ = 1'b1;
    tick();
    RESET_REQ = 1'b0;
    TLU_CLOCK = 1'b0;
    TLU_BUSY = 1'b0;
    check("rr_tlu_reset", 32'(TLU_RESET), 1);
    check("rr_trig", 32'(TLU_TRIGGER), 0);
    check("rr_id", 32'(TRIG_ID), 0);
    check("rr_count", TRIG_COUNT, 0);
    check("rr_err", 32'(TIMEOUT_ERR), 0);
    tick();
    check("rr_tlu_reset_1cyc", 32'(TLU_RESET), 0);
    wait_idle();

    // ID wrap: 17 mode-0 triggers with a 4-bit ID
    MODE = 2'd0;
    ENABLE = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wait_high(n);
      if (k == 0) check("wrap_first_id", 32'(TRIG_ID), 1);
      if (k == 16) ENABLE = 1'b0;
      count_high(h);
    end
    wait_idle();
    check("wrap_id", 32'(TRIG_ID), 1);
    check("wrap_count", TRIG_COUNT, 17);

    // Zero threshold never fires
    RATE_THRESHOLD = 16'h0000;
    ENABLE = 1'b1;
    hi = 0;
    for (int i = 0; i < 10000; i++) begin tick(); hi += int'(TLU_TRIGGER); end
    check("thr0_no_trig", hi, 0);
    check("thr0_count", TRIG_COUNT, 17);

    // System reset in the middle of a pulse
    RATE_THRESHOLD = 16'hFFFF;
    wait_high(n);
    check("srst_rise", 32'(TLU_TRIGGER), 1);
    tick();
    SYS_RST = 1'b1;
    ENABLE = 1'b0;
    tick();
    SYS_RST = 1'b0;
    check("srst_trig", 32'(TLU_TRIGGER), 0);
    check("srst_tlu_reset", 32'(TLU_RESET), 0);
    check("srst_id", 32'(TRIG_ID), 0);
    check("srst_count", TRIG_COUNT, 0);
    check("srst_active", 32'(ACTIVE), 0);
    tick();
    check("srst_no_reset_pulse", 32'(TLU_RESET), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
